spi_loader_master: RTL and testbench

- Synthesizable SPI/QSPI master that writes a stream of 32-bit words into PULPino L2 through the chip-level SPI slave boot port.
- It performs the transmit-side counterpart of the bench's memory-load sequence: optional QPI-enable command, then a write command 0x02, a 32-bit address and N data words.
- Used for FPGA standalone boot from a host-side word stream.
- Write-only: sdi lines are not sampled.

---
 rtl/spi_loader_master.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_loader_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_loader_master.sv
// SPI/QSPI master that streams 32-bit words into PULPino L2 through the boot SPI slave.
// Frame order: optional QPI-enable (reg0 <= 0x01), then write command 0x02, start address and N data words.
module spi_loader_master #(
    parameter int HALF_PERIOD = 2,
    parameter int CS_GAP      = 4,
    parameter int LEN_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             qpi_en_i,
    input  logic [31:0]      addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [31:0]      data_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             spi_sck_o,
    output logic             spi_csn_o,
    output logic [1:0]       spi_mode_o,
    output logic [3:0]       spi_sdo_o
);

    localparam int HP_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [HP_W-1:0]  HP_MAX  = HP_W'(HALF_PERIOD - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(CS_GAP - 1);
    localparam logic [31:0] QPI_WORD = 32'h0101_0000;
    localparam logic [31:0] CMD_WORD = 32'h0200_0000;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        QPI_FRM = 4'd1,
        GAP     = 4'd2,
        CMD     = 4'd3,
        ADDR    = 4'd4,
        LOAD    = 4'd5,
        DATA    = 4'd6,
        TAIL    = 4'd7,
        DONE    = 4'd8
    } state_t;

    state_t           state_r;
    logic [31:0]      sh_r;
    logic [5:0]       units_r;
    logic [HP_W-1:0]  hp_r;
    logic [GAP_W-1:0] gap_r;
    logic             sck_r;
    logic             csn_r;
    logic [3:0]       sdo_r;
    logic [1:0]       mode_r;
    logic             quad_r;
    logic [31:0]      addr_r;
    logic [LEN_W-1:0] len_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             hp_end_s;
    logic             wide_s;

    // Leading shift unit of a left-aligned word: one bit on sdo[0] or one nibble on sdo[3:0].
    function automatic logic [3:0] unit_of(input logic [31:0] v, input logic wide);
        unit_of = wide ? v[31:28] : {3'b000, v[31]};
    endfunction

    function automatic logic [31:0] shift_of(input logic [31:0] v, input logic wide);
        shift_of = wide ? {v[27:0], 4'h0} : {v[30:0], 1'b0};
    endfunction

    assign hp_end_s = (hp_r == HP_MAX);
    // The QPI-enable frame is always single-lane even though quad_r is already set.
    assign wide_s   = quad_r && (state_r != QPI_FRM);

    // Sequencer: frame states, SCK/CSN generation and the shift datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            sh_r    <= 32'h0000_0000;
            units_r <= 6'd0;
            hp_r    <= '0;
            gap_r   <= '0;
            sck_r   <= 1'b0;
            csn_r   <= 1'b1;
            sdo_r   <= 4'h0;
            mode_r  <= 2'b00;
            quad_r  <= 1'b0;
            addr_r  <= 32'h0000_0000;
            len_r   <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            addr_r <= addr_i;
                            len_r  <= len_i;
                            quad_r <= qpi_en_i;
                            busy_r <= 1'b1;
                            csn_r  <= 1'b0;
                            sck_r  <= 1'b0;
                            hp_r   <= '0;
                            if (qpi_en_i) begin
                                state_r <= QPI_FRM;
                                sdo_r   <= unit_of(QPI_WORD, 1'b0);
                                sh_r    <= shift_of(QPI_WORD, 1'b0);
                                units_r <= 6'd16;
                            end else begin
                                state_r <= CMD;
                                sdo_r   <= unit_of(CMD_WORD, 1'b0);
                                sh_r    <= shift_of(CMD_WORD, 1'b0);
                                units_r <= 6'd8;
                            end
                        end else begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                QPI_FRM, CMD, ADDR, DATA: begin
                    if (!hp_end_s) begin
                        hp_r <= hp_r + HP_W'(1);
                    end else begin
                        hp_r <= '0;
                        if (!sck_r) begin
                            sck_r <= 1'b1;
                        end else begin
                            sck_r <= 1'b0;
                            if (units_r != 6'd1) begin
                                sdo_r   <= unit_of(sh_r, wide_s);
                                sh_r    <= shift_of(sh_r, wide_s);
                                units_r <= units_r - 6'd1;
                            end else begin
                                // Last falling edge of the current field: chain into the next one.
                                case (state_r)
                                    QPI_FRM: begin
                                        state_r <= GAP;
                                        csn_r   <= 1'b1;
                                        sdo_r   <= 4'h0;
                                        mode_r  <= 2'b01;
                                        gap_r   <= '0;
                                    end
                                    CMD: begin
                                        state_r <= ADDR;
                                        sdo_r   <= unit_of(addr_r, quad_r);
                                        sh_r    <= shift_of(addr_r, quad_r);
                                        units_r <= quad_r ? 6'd8 : 6'd32;
                                    end
                                    ADDR: begin
                                        state_r <= LOAD;
                                        sdo_r   <= 4'h0;
                                        ready_r <= 1'b1;
                                    end
                                    default: begin
                                        sdo_r <= 4'h0;
                                        if (len_r != '0) begin
                                            state_r <= LOAD;
                                            ready_r <= 1'b1;
                                        end else begin
                                            state_r <= TAIL;
                                            csn_r   <= 1'b1;
                                            mode_r  <= 2'b00;
                                            gap_r   <= '0;
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                end
                LOAD: begin
                    if (data_valid_i && ready_r) begin
                        state_r <= DATA;
                        ready_r <= 1'b0;
                        len_r   <= len_r - LEN_W'(1);
                        hp_r    <= '0;
                        sdo_r   <= unit_of(data_i, quad_r);
                        sh_r    <= shift_of(data_i, quad_r);
                        units_r <= quad_r ? 6'd8 : 6'd32;
                    end else begin
                        state_r <= LOAD;
                    end
                end
                GAP: begin
                    if (gap_r == GAP_MAX) begin
                        state_r <= CMD;
                        csn_r   <= 1'b0;
                        sck_r   <= 1'b0;
                        hp_r    <= '0;
                        sdo_r   <= unit_of(CMD_WORD, 1'b1);
                        sh_r    <= shift_of(CMD_WORD, 1'b1);
                        units_r <= 6'd2;
                    end else begin
                        gap_r <= gap_r + GAP_W'(1);
                    end
                end
                TAIL: begin
                    if (gap_r == GAP_MAX) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        gap_r <= gap_r + GAP_W'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign data_ready_o = ready_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign spi_sck_o    = sck_r;
    assign spi_csn_o    = csn_r;
    assign spi_mode_o   = mode_r;
    assign spi_sdo_o    = sdo_r;

endmodule

// File: tb/tb_spi_loader_master.sv
// Scoreboard bench for spi_loader_master: expected SPI fields are queued at start and
// compared as the monitor decodes them from SCK rising edges.
module tb_spi_loader_master;

    localparam int LEN_W  = 16;
    localparam int BUDGET = 4000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic             qpi_en_i;
    logic [31:0]      addr_i;
    logic [LEN_W-1:0] len_i;
    logic [31:0]      data_i;
    logic             data_valid_i;
    logic             data_ready_o;
    logic             busy_o;
    logic             done_o;
    logic             spi_sck_o;
    logic             spi_csn_o;
    logic [1:0]       spi_mode_o;
    logic [3:0]       spi_sdo_o;

    typedef struct {
        logic [31:0] val;
        int          bits;
        bit          quad;
    } sb_item_t;

    sb_item_t    sb[$];
    logic [31:0] words [4];

    int checks = 0;
    int errors = 0;
    int pulses, csn_hi_pulses, extra_pulses, done_cnt, hs_cnt, ready_cyc, csn_lo_cyc;
    int sdo_bad, gap_runs, gap_last, stall_seen, stall_bad;

    spi_loader_master #(.HALF_PERIOD(2), .CS_GAP(4), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .qpi_en_i     (qpi_en_i),
        .addr_i       (addr_i),
        .len_i        (len_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .spi_sck_o    (spi_sck_o),
        .spi_csn_o    (spi_csn_o),
        .spi_mode_o   (spi_mode_o),
        .spi_sdo_o    (spi_sdo_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        logic        sck_q    = 1'b0;
        logic [3:0]  sdo_q    = 4'h0;
        logic [31:0] acc      = 32'h0;
        int          acc_n    = 0;
        logic [1:0]  acc_mode = 2'b00;
        int          run      = 0;
        sb_item_t    it;
        forever begin
            @(negedge clk);
            if (spi_sck_o && (spi_sdo_o != sdo_q)) sdo_bad++;
            if (spi_csn_o) begin
                acc   = 32'h0;
                acc_n = 0;
            end
            if (spi_sck_o && !sck_q) begin
                pulses++;
                if (spi_csn_o) csn_hi_pulses++;
                if (sb.size() == 0) begin
                    extra_pulses++;
                end else begin
                    if (acc_n == 0) acc_mode = spi_mode_o;
                    if (sb[0].quad) begin
                        acc   = {acc[27:0], spi_sdo_o};
                        acc_n += 4;
                    end else begin
                        if (spi_sdo_o[3:1] != 3'b000) sdo_bad++;
                        acc   = {acc[30:0], spi_sdo_o[0]};
                        acc_n += 1;
                    end
                    if (acc_n >= sb[0].bits) begin
                        it = sb.pop_front();
                        check_eq("field_bits", acc, it.val);
                        check_eq("field_mode", 32'(acc_mode), it.quad ? 32'h1 : 32'h0);
                        acc   = 32'h0;
                        acc_n = 0;
                    end
                end
            end
            if (done_o) done_cnt++;
            if (data_ready_o) ready_cyc++;
            if (!spi_csn_o) csn_lo_cyc++;
            if (data_ready_o && data_valid_i) hs_cnt++;
            if (busy_o && spi_csn_o) begin
                run++;
            end else if (!spi_csn_o && run > 0) begin
                gap_runs++;
                gap_last = run;
                run      = 0;
            end
            if (!busy_o) run = 0;
            sck_q = spi_sck_o;
            sdo_q = spi_sdo_o;
        end
    endtask

    task automatic xfer_start(input bit qpi, input logic [31:0] addr, input int n);
        if (n > 0) begin
            if (qpi) sb.push_back('{32'h0000_0101, 16, 1'b0});
            sb.push_back('{32'h0000_0002, 8, qpi});
            sb.push_back('{addr, 32, qpi});
            for (int i = 0; i < n; i++) sb.push_back('{words[i], 32, qpi});
        end
        pulses = 0; csn_hi_pulses = 0; extra_pulses = 0; done_cnt = 0; hs_cnt = 0;
        ready_cyc = 0; csn_lo_cyc = 0; sdo_bad = 0; gap_runs = 0; gap_last = 0;
        stall_seen = 0; stall_bad = 0;
        start_i  = 1'b1;
        qpi_en_i = qpi;
        addr_i   = addr;
        len_i    = LEN_W'(n);
        @(posedge clk); #1;
        start_i  = 1'b0;
        qpi_en_i = 1'b0;
        addr_i   = 32'hFFFF_FFFF;
        len_i    = '0;
    endtask

    task automatic xfer_run(input int n, input int stall_at, input int stall_len,
                            input bit noise, input int abort_at);
        int   idx        = 0;
        int   stall_left = stall_len;
        int   cyc        = 0;
        logic rdy;
        while (done_cnt == 0 && cyc < BUDGET && !(abort_at > 0 && pulses >= abort_at)) begin
            rdy    = data_ready_o;
            data_i = (idx < n) ? words[idx] : 32'h0;
            if (idx == stall_at && stall_left > 0) begin
                data_valid_i = 1'b0;
                if (rdy) begin
                    stall_seen++;
                    stall_left--;
                    if (spi_sck_o || spi_csn_o) stall_bad++;
                end else if (stall_left != stall_len) begin
                    stall_bad++;
                end
            end else begin
                data_valid_i = (idx < n) || noise;
            end
            if (noise && !rdy) data_i = 32'hBAD0_0000 | 32'(cyc);
            start_i = noise && !rdy && (idx == 1);
            if (rdy && data_valid_i) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        data_valid_i = 1'b0;
        start_i      = 1'b0;
        data_i       = 32'h0;
        check_eq("xfer_timeout", 32'(cyc >= BUDGET), 32'h0);
    endtask

    task automatic xfer_check(input bit qpi, input int n);
        int exp_p = qpi ? (16 + 2 + 8 + 8 * n) : (8 + 32 + 32 * n);
        repeat (4) @(posedge clk);
        #1;
        check_eq("sck_pulses", 32'(pulses), 32'(exp_p));
        check_eq("pulses_csn_high", 32'(csn_hi_pulses), 32'h0);
        check_eq("extra_pulses", 32'(extra_pulses), 32'h0);
        check_eq("sb_left", 32'(sb.size()), 32'h0);
        check_eq("done_pulses", 32'(done_cnt), 32'h1);
        check_eq("busy_after", 32'(busy_o), 32'h0);
        check_eq("words_taken", 32'(hs_cnt), 32'(n));
        check_eq("sdo_unstable", 32'(sdo_bad), 32'h0);
        check_eq("csn_gaps", 32'(gap_runs), qpi ? 32'h1 : 32'h0);
        check_eq("csn_gap_len", 32'(gap_last), qpi ? 32'h4 : 32'h0);
        check_eq("mode_after", 32'(spi_mode_o), 32'h0);
        check_eq("csn_after", 32'(spi_csn_o), 32'h1);
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        qpi_en_i     = 1'b0;
        addr_i       = 32'h0;
        len_i        = '0;
        data_i       = 32'h0;
        data_valid_i = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_sck", 32'(spi_sck_o), 32'h0);
        check_eq("rst_csn", 32'(spi_csn_o), 32'h1);
        check_eq("rst_mode", 32'(spi_mode_o), 32'h0);
        check_eq("rst_sdo", 32'(spi_sdo_o), 32'h0);
        check_eq("rst_ready", 32'(data_ready_o), 32'h0);
        check_eq("rst_busy", 32'(busy_o), 32'h0);
        check_eq("rst_done", 32'(done_o), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single lane, one word, valid held high
        words[0] = 32'h1234_5678;
        xfer_start(1'b0, 32'h0000_0000, 1);
        xfer_run(1, -1, 0, 1'b0, 0);
        xfer_check(1'b0, 1);

        // QPI enable followed by a quad write of two words
        words[0] = 32'hDEAD_BEEF;
        words[1] = 32'hCAFE_F00D;
        xfer_start(1'b1, 32'h0010_0000, 2);
        xfer_run(2, -1, 0, 1'b0, 0);
        xfer_check(1'b1, 2);

        // Source stalls 50 cycles before the second word
        words[0] = 32'h1111_0001;
        words[1] = 32'h2222_0002;
        words[2] = 32'h3333_0003;
        xfer_start(1'b0, 32'h0000_1000, 3);
        xfer_run(3, 1, 50, 1'b0, 0);
        check_eq("stall_cycles", 32'(stall_seen), 32'd50);
        check_eq("stall_bad", 32'(stall_bad), 32'h0);
        xfer_check(1'b0, 3);

        // Zero-length start completes with no SPI activity
        xfer_start(1'b0, 32'h0000_2000, 0);
        check_eq("len0_done_next", 32'(done_o), 32'h1);
        check_eq("len0_busy", 32'(busy_o), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("len0_done_cnt", 32'(done_cnt), 32'h1);
        check_eq("len0_pulses", 32'(pulses), 32'h0);
        check_eq("len0_ready", 32'(ready_cyc), 32'h0);
        check_eq("len0_csn_low", 32'(csn_lo_cyc), 32'h0);

        // Reset in the middle of the address field, then a clean transfer
        words[0] = 32'h5555_AAAA;
        xfer_start(1'b0, 32'hA5A5_5A5A, 1);
        xfer_run(1, -1, 0, 1'b0, 20);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_csn", 32'(spi_csn_o), 32'h1);
        check_eq("midrst_sck", 32'(spi_sck_o), 32'h0);
        check_eq("midrst_sdo", 32'(spi_sdo_o), 32'h0);
        check_eq("midrst_busy", 32'(busy_o), 32'h0);
        check_eq("midrst_ready", 32'(data_ready_o), 32'h0);
        rst = 1'b0;
        sb.delete();
        repeat (6) @(posedge clk);
        #1;
        check_eq("midrst_no_done", 32'(done_cnt), 32'h0);
        words[0] = 32'h0BAD_F00D;
        xfer_start(1'b0, 32'h0000_0040, 1);
        xfer_run(1, -1, 0, 1'b0, 0);
        xfer_check(1'b0, 1);

        // Start pulses during DATA and garbage valid outside LOAD
        words[0] = 32'h8765_4321;
        words[1] = 32'h0F0F_F0F0;
        xfer_start(1'b0, 32'h0000_3000, 2);
        xfer_run(2, -1, 0, 1'b1, 0);
        xfer_check(1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
